// File: rtl/masked_share_decoder_if.sv
// Handshake bundle for masked_share_decoder: masked sharing and randomness in, unmasked word out.
// The decoder takes the slave modport; the producer/consumer side takes the master modport.
interface masked_share_decoder_if #(
  parameter int security_order = 1,
  parameter int WIDTH          = 8
) ();
  logic                                in_valid;
  logic                                in_ready;
  logic [(security_order+1)*WIDTH-1:0] in_shares;
  logic                                rnd_req;
  logic [security_order*WIDTH-1:0]     r;
  logic                                out_valid;
  logic                                out_ready;
  logic [WIDTH-1:0]                    out_data;

  modport master (
    output in_valid, in_shares, r, out_ready,
    input  in_ready, rnd_req, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_shares, r, out_ready,
    output in_ready, rnd_req, out_valid, out_data
  );
endinterface

// File: rtl/masked_share_decoder.sv
// Refreshes a (d+1)-share Boolean masking, then folds one share per cycle; out_valid d+3 edges after accept, held under stall.
// MASKED_SHARE_DECODER_ZERO_OUT_EN forces out_data to 0 while out_valid is low; otherwise out_data tracks the accumulator.
module masked_share_decoder #(
  parameter int security_order = 1,
  parameter int WIDTH          = 8
) (
  input logic                   clk,
  input logic                   rst,
  masked_share_decoder_if.slave bus
);

  localparam int NSH = security_order + 1;
  localparam int CW  = (NSH > 1) ? $clog2(NSH) : 1;

  typedef enum logic [1:0] {IDLE, REFRESH, FOLD, OUT} state_e;
  typedef logic [NSH-1:0][WIDTH-1:0] shares_t;

  state_e           state_q, state_d;
  shares_t          share_q, share_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             rnd_req_q, rnd_req_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] rmix;

  logic accept;
  logic out_hs;
  logic last_fold;

  assign accept    = bus.in_valid & in_ready_q;
  assign out_hs    = out_valid_q & bus.out_ready;
  assign last_fold = (cnt_q == CW'(security_order));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REFRESH;
      REFRESH: state_d = FOLD;
      FOLD:    if (last_fold) state_d = OUT;
      OUT:     if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so nothing on the ports is combinational.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    rnd_req_d   = (state_d == REFRESH);
    out_valid_d = (state_q == OUT) && !out_hs;
`ifdef MASKED_SHARE_DECODER_ZERO_OUT_EN
    out_data_d  = out_valid_d ? acc_d : '0;
`else
    out_data_d  = acc_d;
`endif
  end

  // The last share absorbs the XOR of all fresh words, so the encoded value is unchanged.
  always_comb begin
    share_d = share_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rmix    = '0;
    case (state_q)
      IDLE: begin
        if (accept) share_d = bus.in_shares;
      end
      REFRESH: begin
        for (int i = 0; i < security_order; i++) begin
          share_d[i] = share_q[i] ^ bus.r[i*WIDTH +: WIDTH];
          rmix       = rmix ^ bus.r[i*WIDTH +: WIDTH];
        end
        share_d[security_order] = share_q[security_order] ^ rmix;
        acc_d = '0;
        cnt_d = '0;
      end
      FOLD: begin
        acc_d = acc_q ^ share_q[cnt_q];
        if (!last_fold) cnt_d = cnt_q + CW'(1);
      end
      OUT: begin
        if (out_hs) begin
          share_d = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      share_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      rnd_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      share_q     <= share_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      rnd_req_q   <= rnd_req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rnd_req   = rnd_req_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_masked_share_decoder.sv
// Directed bench for masked_share_decoder at d=1 and d=2 with hand-computed results.
module tb_masked_share_decoder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  masked_share_decoder_if #(.security_order(1), .WIDTH(8)) b1 ();
  masked_share_decoder_if #(.security_order(2), .WIDTH(8)) b2 ();

  masked_share_decoder #(.security_order(1), .WIDTH(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  masked_share_decoder #(.security_order(2), .WIDTH(8)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One d=2 transaction: accept, refresh, fold, optional stall in OUT, handshake.
  task automatic run_d2(input string tag, input logic [23:0] sh, input logic [15:0] rr,
                        input logic [7:0] exp, input int stall, input bit busy);
    int edges;
    b2.in_shares = sh;
    b2.r         = rr;
    b2.in_valid  = 1'b1;
    b2.out_ready = (stall == 0);
    step();
    edges = 0;
    if (busy) begin
      b2.in_valid  = 1'b1;
      b2.in_shares = 24'hFF_C3_0F;
    end else begin
      b2.in_valid  = 1'b0;
    end
    chk({tag, "_rnd_req"}, 32'(b2.rnd_req), 32'd1);
    chk({tag, "_busy_in_ready"}, 32'(b2.in_ready), 32'd0);
`ifdef MASKED_SHARE_DECODER_ZERO_OUT_EN
    chk({tag, "_zero_out"}, 32'(b2.out_data), 32'd0);
`endif
    step();
    edges = 1;
    b2.r = 16'hBEEF;
    chk({tag, "_rnd_req_drop"}, 32'(b2.rnd_req), 32'd0);
    while (!b2.out_valid && edges < 30) begin
`ifdef MASKED_SHARE_DECODER_ZERO_OUT_EN
      chk({tag, "_zero_out"}, 32'(b2.out_data), 32'd0);
`endif
      step();
      edges++;
    end
    b2.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(edges), 32'd5);
    chk({tag, "_data"}, 32'(b2.out_data), 32'(exp));
    for (int k = 0; k < stall; k++) begin
      step();
      chk({tag, "_stall_valid"}, 32'(b2.out_valid), 32'd1);
      chk({tag, "_stall_data"}, 32'(b2.out_data), 32'(exp));
      chk({tag, "_stall_in_ready"}, 32'(b2.in_ready), 32'd0);
    end
    b2.out_ready = 1'b1;
    step();
    chk({tag, "_post_valid"}, 32'(b2.out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(b2.in_ready), 32'd1);
`ifdef MASKED_SHARE_DECODER_ZERO_OUT_EN
    chk({tag, "_post_zero_out"}, 32'(b2.out_data), 32'd0);
`endif
  endtask

  initial begin
    int edges;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    b1.in_valid  = 1'b0;
    b1.in_shares = '0;
    b1.r         = '0;
    b1.out_ready = 1'b0;
    b2.in_valid  = 1'b0;
    b2.in_shares = '0;
    b2.r         = '0;
    b2.out_ready = 1'b0;

    step();
    chk("rst_in_ready1", 32'(b1.in_ready), 32'd1);
    chk("rst_out_valid1", 32'(b1.out_valid), 32'd0);
    chk("rst_rnd_req1", 32'(b1.rnd_req), 32'd0);
    chk("rst_out_data1", 32'(b1.out_data), 32'd0);
    chk("rst_in_ready2", 32'(b2.in_ready), 32'd1);
    chk("rst_out_valid2", 32'(b2.out_valid), 32'd0);
    chk("rst_out_data2", 32'(b2.out_data), 32'd0);
    rst = 1'b0;
    step();

    // d=1: 0xA5 ^ 0x3C = 0x99, refresh with 0x5F cancels out
    b1.in_shares = {8'h3C, 8'hA5};
    b1.r         = 8'h5F;
    b1.in_valid  = 1'b1;
    b1.out_ready = 1'b1;
    step();
    b1.in_valid = 1'b0;
    chk("d1_rnd_req", 32'(b1.rnd_req), 32'd1);
    chk("d1_in_ready_busy", 32'(b1.in_ready), 32'd0);
    step();
    edges = 1;
    b1.r = 8'hFF;
    chk("d1_rnd_req_drop", 32'(b1.rnd_req), 32'd0);
    while (!b1.out_valid && edges < 20) begin
      step();
      edges++;
    end
    chk("d1_latency", 32'(edges), 32'd4);
    chk("d1_data", 32'(b1.out_data), 32'h99);
    step();
    chk("d1_post_valid", 32'(b1.out_valid), 32'd0);
    chk("d1_post_in_ready", 32'(b1.in_ready), 32'd1);

    // d=2: 0x12 ^ 0x34 ^ 0x56 = 0x70 regardless of refresh randomness
    run_d2("d2_r0", {8'h56, 8'h34, 8'h12}, {8'h00, 8'h00}, 8'h70, 0, 1'b0);
    run_d2("d2_r1", {8'h56, 8'h34, 8'h12}, {8'h81, 8'hFF}, 8'h70, 0, 1'b0);
    run_d2("d2_stall", {8'h56, 8'h34, 8'h12}, {8'h81, 8'hFF}, 8'h70, 10, 1'b0);
    run_d2("d2_busy", {8'h56, 8'h34, 8'h12}, {8'h5A, 8'hC3}, 8'h70, 0, 1'b1);

    // Reset one edge into folding: transaction dropped, block back to idle
    b2.in_shares = {8'h56, 8'h34, 8'h12};
    b2.r         = 16'h1234;
    b2.in_valid  = 1'b1;
    b2.out_ready = 1'b1;
    step();
    b2.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_in_ready", 32'(b2.in_ready), 32'd1);
    chk("rstmid_out_valid", 32'(b2.out_valid), 32'd0);
    chk("rstmid_out_data", 32'(b2.out_data), 32'd0);
    chk("rstmid_rnd_req", 32'(b2.rnd_req), 32'd0);
    // 0xAA ^ 0xF0 ^ 0x0F = 0x55
    run_d2("d2_after_rst", {8'h0F, 8'hF0, 8'hAA}, {8'h37, 8'h13}, 8'h55, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_share_decoder.md
Name: masked_share_decoder

Overview:
- Recombines a Boolean (d+1)-share masked word into its unmasked value. It is the output end of the masked datapath; masked AND/XOR gadgets produce these sharings.
- Shares are refreshed with fresh randomness before being folded serially, one share per cycle, into an accumulator. No two raw input shares are ever combined in the same cycle.
- Valid/ready handshake on input and output; one transaction in flight at a time.

Parameters:
- security_order, 1, masking order d; the block accepts d+1 shares.
- WIDTH, 8, bit width of the unmasked word.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input sharing is valid.
- in_ready  output  1  block can accept a sharing.
- in_shares  input  (security_order+1)*WIDTH  share i at bits [i*WIDTH +: WIDTH].
- rnd_req  output  1  high for exactly the cycle in which r is consumed.
- r  input  security_order*WIDTH  fresh randomness; word i at [i*WIDTH +: WIDTH].
- out_valid  output  1  unmasked result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  unmasked word.

Behaviour:
- States: IDLE, REFRESH, FOLD, OUT.
- Reset values, at the first edge with rst=1: state=IDLE, in_ready=1, out_valid=0, rnd_req=0, out_data=0, share registers=0, fold counter=0.
- rst has priority over every other event, including mid-FOLD or OUT. Any in-flight transaction is dropped with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register all shares, go to REFRESH.
- REFRESH (1 cycle):
  - rnd_req=1.
  - For i<d, share_i ^= r_i.
  - share_d ^= XOR of r_0..r_{d-1}.
  - This preserves the shared value.
  - Set acc=0 and counter=0, go to FOLD.
- FOLD (d+1 cycles):
  - Each cycle acc ^= share[counter], then counter++.
  - After share d is folded, go to OUT.
  - The counter is clog2(d+1) bits wide (minimum 1) and never wraps within a transaction.
- OUT:
  - out_valid=1, out_data=acc.
  - Both are held stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE and clear all share registers and acc to 0.
- in_ready is low in REFRESH, FOLD and OUT. in_valid in those states is ignored and not captured.
- Latency:
  - out_valid rises d+3 edges after the accepting edge (1 REFRESH cycle + d+1 FOLD cycles + 1 registered transition).
  - Earliest next accept is the edge after output handshake + 1 cycle, because IDLE is re-entered first.
- Back-pressure: out_ready may stay low indefinitely; nothing changes while stalled.
- out_valid&out_ready in the same cycle the result first appears completes immediately.
- r is sampled only while rnd_req=1; values of r in other cycles have no effect.
- All outputs are driven from registers; no combinational path from in_* to out_*.

Optional Feature:
- Macro: MASKED_SHARE_DECODER_ZERO_OUT_EN.
- Defined: out_data is forced to 0 whenever out_valid=0, so partial accumulator values never appear on the port.
- Undefined: out_data exposes the acc register in every state. Its value is undefined and must be ignored when out_valid=0, but it is 0 after reset.

Test Plan:
- d=1, WIDTH=8: shares {0xA5,0x3C}, r=0x5F, out_ready=1 -> rnd_req high 1 cycle after accept; out_valid 4 edges after accept; out_data=0x99.
- d=2, WIDTH=8: shares {0x12,0x34,0x56}. Run with r={0x00,0x00} and again with r={0xFF,0x81} -> out_data=0x70 both times; out_valid 5 edges after accept.
- Back-pressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data stay constant, in_ready=0; raise out_ready -> one handshake, then in_ready=1 on the next cycle.
- Busy input: assert in_valid with different shares during REFRESH/FOLD -> no capture; result matches the first transaction only.
- Reset mid-FOLD: pulse rst at fold step 1 -> next edge state=IDLE, out_valid=0, out_data=0, in_ready=1; a fresh transaction then decodes correctly.
- Feature macro: with MASKED_SHARE_DECODER_ZERO_OUT_EN defined, out_data=0 in every cycle with out_valid=0 during a d=2 run. Without the macro, the same run produces out_data=0x70 when valid.
